// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner: 3-digit time-multiplexed common-cathode 7-segment driver.
// Each digit slot begins with a short all-anodes-off interval to stop ghosting.
// A new BCD word is committed only at a frame boundary, so a frame never mixes
// two values.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zeros on the
// hundreds and tens digits.
module bcd_7seg_scanner #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  typedef enum logic {ST_BLANK, ST_ON} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_e           state_q, state_d;
  logic [11:0]      disp_q, disp_d;
  logic [11:0]      pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_end;
  logic [3:0]       nibble;
  logic             blank_digit;

  // Segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  assign frame_end = (idx_q == 2'd2) && (cnt_q == CNT_LAST);

  // Prescaler and digit index: wrap the slot counter, then step to the next digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Select the nibble for the active digit.
  always_comb begin
    case (idx_q)
      2'd1:    nibble = disp_q[7:4];
      2'd2:    nibble = disp_q[11:8];
      default: nibble = disp_q[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero suppression: hundreds if zero, tens if hundreds and tens are zero.
  always_comb begin
    case (idx_q)
      2'd2:    blank_digit = (disp_q[11:8] == 4'd0);
      2'd1:    blank_digit = (disp_q[11:4] == 8'd0);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  // FSM next state tracks the phase of the next prescaler value; outputs come
  // from the current phase and land in registers one cycle later.
  always_comb begin
    state_d      = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_ON;
    an_d         = 3'b111;
    seg_d        = 7'h00;
    frame_done_d = frame_end;
    if (state_q == ST_ON) begin
      an_d  = ~(3'b001 << idx_q);
      seg_d = blank_digit ? 7'h00 : decode(nibble);
    end
  end

  // Input capture: strobes park in pend_q; a strobe on the frame-end cycle
  // bypasses the pending register and commits directly.
  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    disp_d      = disp_q;
    if (frame_end) begin
      if (bcd_valid) begin
        disp_d      = bcd_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        disp_d      = pend_q;
        pend_flag_d = 1'b0;
      end
    end else if (bcd_valid) begin
      pend_d      = bcd_in;
      pend_flag_d = 1'b1;
    end
  end

  // State registers; asynchronous reset discards any pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      disp_q       <= 12'h000;
      pend_q       <= 12'h000;
      pend_flag_q  <= 1'b0;
      seg_q        <= 7'h00;
      an_q         <= 3'b111;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// tb_bcd_7seg_scanner: directed checks of scan timing, frame-boundary capture,
// decoding, reset and (when LEADING_ZERO_BLANK_EN is defined) zero blanking.
module tb_bcd_7seg_scanner;

  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        bcd_valid = 1'b0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_7seg_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference segment table.
  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    return tbl[n];
  endfunction

  // Expected lit pattern of digit i for a displayed word.
  function automatic logic [6:0] exp_digit(input logic [11:0] w, input int i);
    logic [3:0] n;
    n = (i == 0) ? w[3:0] : (i == 1) ? w[7:4] : w[11:8];
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 2 && w[11:8] == 4'd0) return 7'h00;
    if (i == 1 && w[11:4] == 8'd0) return 7'h00;
`endif
    return ref_seg(n);
  endfunction

  // Runs one 24-cycle frame, starting right after a frame boundary edge, and
  // records samples. Up to two strobes can be injected at step indices s1/s2;
  // step k's rising edge sees prescaler k%8 on digit k/8.
  task automatic run_frame(input int s1, input logic [11:0] w1,
                           input int s2, input logic [11:0] w2,
                           output logic [2:0][6:0] seg_on,
                           output logic [2:0][6:0] seg_blank,
                           output logic [2:0][2:0] an_blank,
                           output logic [2:0][2:0] an_on,
                           output int fd_cnt, output logic fd_last);
    fd_cnt = 0;
    fd_last = 1'b0;
    for (int k = 0; k < 3 * DC; k++) begin
      bcd_valid = (k == s1) || (k == s2);
      bcd_in    = (k == s2) ? w2 : (k == s1) ? w1 : 12'hFFF;
      @(negedge clk);
      bcd_valid = 1'b0;
      if (frame_done) fd_cnt++;
      if (k % DC == BC - 1) begin
        an_blank[k / DC]  = an;
        seg_blank[k / DC] = seg;
      end
      if (k % DC == BC) an_on[k / DC] = an;
      if (k % DC == DC - 1) seg_on[k / DC] = seg;
      if (k == 3 * DC - 1) fd_last = frame_done;
    end
  endtask

  logic [2:0][6:0] s_on, s_bl;
  logic [2:0][2:0] a_bl, a_on;
  int              fdc;
  logic            fdl;

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (an !== 3'b111) $display("FAIL reset_an: got %b want 111", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h00) $display("FAIL reset_seg: got %h want 00", seg); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done); else pass_cnt++;
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
      for (int i = 0; i < 3; i++) begin
        logic [2:0] want_an;
        want_an = ~(3'b001 << i);
        total_cnt++; if (a_bl[i] !== 3'b111) $display("FAIL scan_blank_an f%0d d%0d: got %b want 111", f, i, a_bl[i]); else pass_cnt++;
        total_cnt++; if (s_bl[i] !== 7'h00) $display("FAIL scan_blank_seg f%0d d%0d: got %h want 00", f, i, s_bl[i]); else pass_cnt++;
        total_cnt++; if (a_on[i] !== want_an) $display("FAIL scan_on_an f%0d d%0d: got %b want %b", f, i, a_on[i], want_an); else pass_cnt++;
        total_cnt++; if (s_on[i] !== exp_digit(12'h000, i)) $display("FAIL scan_seg f%0d d%0d: got %h want %h", f, i, s_on[i], exp_digit(12'h000, i)); else pass_cnt++;
      end
      total_cnt++; if (fdc !== 1) $display("FAIL fd_count f%0d: got %0d want 1", f, fdc); else pass_cnt++;
      total_cnt++; if (fdl !== 1'b1) $display("FAIL fd_position f%0d: got %b want 1", f, fdl); else pass_cnt++;
    end
  endtask

  // Compares the lit patterns of a captured frame against a word.
  task automatic test_frame_shows(input string name, input logic [11:0] w);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (s_on[i] !== exp_digit(w, i))
        $display("FAIL %s d%0d: got %h want %h", name, i, s_on[i], exp_digit(w, i));
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_frame_strobe;
    run_frame(10, 12'h127, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("hold_until_frame_end", 12'h000);
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("show_127", 12'h127);
  endtask

  task automatic test_back_to_back;
    run_frame(4, 12'h045, 15, 12'h099, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("b2b_hold_127", 12'h127);
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("b2b_last_wins_099", 12'h099);
  endtask

  task automatic test_frame_end_strobe;
    run_frame(3 * DC - 1, 12'h063, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("fe_hold_099", 12'h099);
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("fe_direct_063", 12'h063);
  endtask

  task automatic test_invalid_bcd;
    run_frame(3, 12'h0A5, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("dash_0A5", 12'h0A5);
    total_cnt++; if (s_on[1] !== 7'h40) $display("FAIL dash_tens: got %h want 40", s_on[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan;
    for (int k = 0; k < 12; k++) begin
      bcd_valid = (k == 5);
      bcd_in    = 12'h088;
      @(negedge clk);
      bcd_valid = 1'b0;
    end
    total_cnt++; if (an !== 3'b101) $display("FAIL pre_reset_an: got %b want 101", an); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (an !== 3'b111) $display("FAIL async_reset_an: got %b want 111", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h00) $display("FAIL async_reset_seg: got %h want 00", seg); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("post_reset_000", 12'h000);
    total_cnt++; if (a_on[0] !== 3'b110) $display("FAIL restart_digit0: got %b want 110", a_on[0]); else pass_cnt++;
    total_cnt++; if (fdl !== 1'b1) $display("FAIL restart_fd: got %b want 1", fdl); else pass_cnt++;
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("pending_discarded", 12'h000);
  endtask

  task automatic test_leading_zero;
    run_frame(8, 12'h007, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    run_frame(-1, 12'h0, -1, 12'h0, s_on, s_bl, a_bl, a_on, fdc, fdl);
    test_frame_shows("lzb_007", 12'h007);
    total_cnt++; if (a_on[2] !== 3'b011) $display("FAIL lzb_anode_on: got %b want 011", a_on[2]); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_mid_frame_strobe;
    test_back_to_back;
    test_frame_end_strobe;
    test_invalid_bcd;
    test_reset_mid_scan;
    test_leading_zero;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
